mine_neighbor_count: RTL and testbench

//  Consumes the 25-bit mine map produced by the mine-placement RNG stage and computes,
//  for every cell of the ROWS x COLS board, the number of mines in its 8-neighbourhood.

---
 rtl/mine_neighbor_count.sv | 175 +++++++++++++++++
 tb/tb_mine_neighbor_count.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mine_neighbor_count.sv
// Purpose : per-cell 8-neighbour mine count over a ROWS x COLS board, streamed one cell per clock.
// Latency : start -> 1 LOAD cycle -> CELLS write cycles -> 1 DONE pulse; CELLS+3 cycles per scan.
// Backpr. : none; the consumer must take every write, and in_start outside IDLE is dropped (no queue).
//
// Ports:
//   in_clka      clock, all logic on rising edge
//   in_rst_n     synchronous active-low reset
//   in_start     scan request, only honoured in IDLE
//   in_mines     mine map, bit i = cell i = row*COLS+col, captured during LOAD
//   out_busy     high while loading or scanning
//   out_done     one-cycle pulse after the last cell has been written
//   out_wr_en    write strobe for the board-state RAM
//   out_wr_addr  cell index of the current result (0 when not writing)
//   out_wr_data  neighbour count 0..8 or MINE_CODE (0 when not writing)
//   out_counts   result bank, nibble i = cell i, cleared on LOAD and held afterwards

module mine_neighbor_count #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int AW        = 5,
  parameter int MINE_CODE = 15,
  localparam int CELLS    = ROWS * COLS
) (
  input  logic               in_clka,
  input  logic               in_rst_n,
  input  logic               in_start,
  input  logic [CELLS-1:0]   in_mines,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_wr_en,
  output logic [AW-1:0]      out_wr_addr,
  output logic [3:0]         out_wr_data,
  output logic [4*CELLS-1:0] out_counts
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CELLS-1:0]   map_q;
  logic [4*CELLS-1:0] counts_q;
  logic [AW-1:0]      idx_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;

  logic               scan_wr;
  logic               last_cell;
  logic [3:0]         nb_cnt;
  logic [3:0]         cell_res;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_cell = (idx_q == AW'(CELLS - 1));

  // ------------------------------------------------------------------
  // Next state and control outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    out_busy = 1'b0;
    out_done = 1'b0;
    scan_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_busy = 1'b1;
        state_d  = SCAN;
      end
      SCAN: begin
        out_busy = 1'b1;
        scan_wr  = 1'b1;
        if (last_cell) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Neighbour count for the cell at (row_q, col_q).
  // Off-board positions are skipped explicitly so there is no wrap
  // between the end of one row and the start of the next.
  // ------------------------------------------------------------------
  always_comb begin
    nb_cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int nr;
        int nc;
        logic [AW-1:0] nidx;
        nr   = int'(row_q) + dr;
        nc   = int'(col_q) + dc;
        nidx = AW'(nr * COLS + nc);
        if (!(dr == 0 && dc == 0) &&
            nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
          nb_cnt = nb_cnt + 4'(map_q[nidx]);
        end
      end
    end
  end

  assign cell_res = map_q[idx_q] ? 4'(MINE_CODE) : nb_cnt;

  // Write port is forced to zero outside SCAN so the RAM side sees clean idle values.
  assign out_wr_en   = scan_wr;
  assign out_wr_addr = scan_wr ? idx_q : '0;
  assign out_wr_data = scan_wr ? cell_res : 4'd0;
  assign out_counts  = counts_q;

  // ------------------------------------------------------------------
  // Datapath: map capture, cell walk and result bank.
  // row/col advance alongside idx so no divider is needed.
  // ------------------------------------------------------------------
  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      map_q    <= '0;
      counts_q <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          map_q    <= in_mines;
          counts_q <= '0;
          idx_q    <= '0;
          row_q    <= '0;
          col_q    <= '0;
        end
        SCAN: begin
          counts_q[idx_q*4 +: 4] <= cell_res;
          idx_q                  <= idx_q + AW'(1);
          if (col_q == CW'(COLS - 1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mine_neighbor_count.sv
// Purpose : directed self-checking bench for mine_neighbor_count.
// Latency : checks the start -> LOAD -> 25 writes -> done timeline cycle by cycle.
// Backpr. : n/a; stimulus driven and outputs sampled on the falling clock edge.

module tb_mine_neighbor_count;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [24:0]  mines;
  logic         busy;
  logic         done;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [3:0]   wr_data;
  logic [99:0]  counts;

  int checks;
  int errors;

  mine_neighbor_count dut (
    .in_clka     (clk),
    .in_rst_n    (rst_n),
    .in_start    (start),
    .in_mines    (mines),
    .out_busy    (busy),
    .out_done    (done),
    .out_wr_en   (wr_en),
    .out_wr_addr (wr_addr),
    .out_wr_data (wr_data),
    .out_counts  (counts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [99:0] set_nib(input logic [99:0] v, input int i, input logic [3:0] n);
    logic [99:0] r;
    r = v;
    r[4*i +: 4] = n;
    return r;
  endfunction

  // Full scan: start pulsed, every write checked for address order and data,
  // done timing, final bank, and no restart afterwards. With glitch set,
  // in_mines is corrupted and in_start pulsed while scanning.
  task automatic do_scan(input logic [24:0] m, input logic [99:0] exp, input string tag,
                         input bit glitch);
    int nxt;
    int done_cyc;
    @(negedge clk);
    mines = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_busy"}, busy, 1);
    chk({tag, "_load_wren"}, wr_en, 0);
    nxt = 0;
    done_cyc = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (glitch && k == 5)  mines = ~m;
      if (glitch && k == 10) start = 1'b1;
      if (glitch && k == 11) start = 1'b0;
      if (wr_en) begin
        if (nxt < 25) begin
          chk({tag, "_addr"}, wr_addr, nxt);
          chk({tag, "_data"}, wr_data, exp[4*nxt +: 4]);
        end
        nxt++;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    chk({tag, "_nwrites"}, nxt, 25);
    chk({tag, "_done_cycle"}, done_cyc, 27);
    chk({tag, "_counts"}, counts, exp);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_addr"}, wr_addr, 0);
    @(negedge clk);
    chk({tag, "_no_requeue"}, busy, 0);
    mines = m;
  endtask

  logic [99:0] exp_center;
  logic [99:0] exp_corner;
  logic [99:0] exp_full;
  logic [99:0] exp_hole;
  logic [99:0] all_f;

  initial begin
    int d1;
    int d2;
    bit seen;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mines  = '0;

    all_f = {25{4'hF}};
    exp_full = all_f;
    exp_hole = set_nib(all_f, 12, 4'd8);
    exp_center = '0;
    exp_center = set_nib(exp_center, 6, 4'd1);
    exp_center = set_nib(exp_center, 7, 4'd1);
    exp_center = set_nib(exp_center, 8, 4'd1);
    exp_center = set_nib(exp_center, 11, 4'd1);
    exp_center = set_nib(exp_center, 13, 4'd1);
    exp_center = set_nib(exp_center, 16, 4'd1);
    exp_center = set_nib(exp_center, 17, 4'd1);
    exp_center = set_nib(exp_center, 18, 4'd1);
    exp_center = set_nib(exp_center, 12, 4'hF);
    exp_corner = '0;
    exp_corner = set_nib(exp_corner, 1, 4'd1);
    exp_corner = set_nib(exp_corner, 5, 4'd1);
    exp_corner = set_nib(exp_corner, 6, 4'd1);
    exp_corner = set_nib(exp_corner, 3, 4'd1);
    exp_corner = set_nib(exp_corner, 8, 4'd1);
    exp_corner = set_nib(exp_corner, 9, 4'd1);
    exp_corner = set_nib(exp_corner, 0, 4'hF);
    exp_corner = set_nib(exp_corner, 4, 4'hF);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_counts", counts, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    do_scan(25'h0001000, exp_center, "center", 1'b1);
    do_scan(25'h0000011, exp_corner, "corner", 1'b0);
    chk("no_wrap_cell5", counts[4*5 +: 4], 1);
    do_scan(25'h1FFFFFF, exp_full, "full", 1'b0);
    do_scan(25'h0000000, '0, "empty", 1'b0);
    do_scan(25'h1FFEFFF, exp_hole, "hole", 1'b0);

    // Reset during the write of idx 10 aborts the scan completely
    @(negedge clk);
    mines = 25'h0001000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 5'd10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reached_idx10", seen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wren", wr_en, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_counts", counts, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("abort_quiet", {done, wr_en, busy}, 0);
    end
    do_scan(25'h0000011, exp_corner, "after_abort", 1'b0);

    // in_start held high: one scan per IDLE visit, period CELLS+3
    @(negedge clk);
    mines = 25'h0001000;
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
        end else begin
          d2 = k;
          break;
        end
      end
    end
    start = 1'b0;
    chk("hold_first_done", d1, 26);
    chk("hold_period", d2 - d1, 28);
    chk("hold_counts", counts, exp_center);
    repeat (35) @(negedge clk);
    chk("hold_end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
